// File: rtl/drp_reg_responder.sv
// DRP slave exposing NREGS 16-bit registers with a fixed, configurable response latency.
// One transaction is in flight at a time; requests arriving while busy are dropped and counted.
module drp_reg_responder #(
  parameter int         NREGS     = 16,
  parameter logic [8:0] BASE_ADDR = 9'h000,
  parameter int         LATENCY   = 4
) (
  input  logic                 drp_clk,
  input  logic                 rst_n,
  input  logic                 drpen_i,
  input  logic                 drpwe_i,
  input  logic [8:0]           drpaddr_i,
  input  logic [15:0]          drpdi_i,
  output logic                 drprdy_o,
  output logic [15:0]          drpdo_o,
  output logic [NREGS*16-1:0]  regs_o,
  output logic [NREGS-1:0]     wr_strobe_o,
  output logic                 addr_err_o,
  output logic                 busy_o,
  output logic [7:0]           collision_cnt_o
);

  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        accept, commit;
  logic [8:0]  addr_q;
  logic [15:0] di_q;
  logic        we_q;
  logic [15:0] regs [NREGS];
  logic [7:0]  coll_cnt;

  logic [8:0]  c_addr, c_off, off_q;
  logic [15:0] c_di;
  logic        c_we, hit, ack;

  function automatic logic in_range(input logic [8:0] a);
    logic [8:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && (off < 9'(NREGS));
  endfunction

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (drpen_i) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_next = ACK;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = ACK;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The register is written on the edge entering ACK; with LATENCY=1 that is
  // the accepting edge itself, so the live inputs must be used instead of the latch.
  assign c_addr = (state == IDLE) ? drpaddr_i : addr_q;
  assign c_di   = (state == IDLE) ? drpdi_i   : di_q;
  assign c_we   = (state == IDLE) ? drpwe_i   : we_q;
  assign c_off  = c_addr - BASE_ADDR;

  always_ff @(posedge drp_clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      coll_cnt <= 8'h00;
      for (int i = 0; i < NREGS; i++) regs[i] <= 16'h0000;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (drpen_i && (state != IDLE) && (coll_cnt != 8'hFF))
        coll_cnt <= coll_cnt + 8'd1;
      if (commit && c_we && in_range(c_addr)) begin
        for (int i = 0; i < NREGS; i++)
          if (c_off == 9'(i)) regs[i] <= c_di;
      end
    end
  end

  always_ff @(posedge drp_clk) begin
    if (accept) begin
      addr_q <= drpaddr_i;
      di_q   <= drpdi_i;
      we_q   <= drpwe_i;
    end
  end

  assign ack             = (state == ACK);
  assign hit             = in_range(addr_q);
  assign off_q           = addr_q - BASE_ADDR;
  assign drprdy_o        = ack;
  assign busy_o          = (state != IDLE);
  assign addr_err_o      = ack && !hit;
  assign collision_cnt_o = coll_cnt;

  always_comb begin
    drpdo_o     = 16'h0000;
    wr_strobe_o = '0;
    if (ack && hit) begin
      for (int i = 0; i < NREGS; i++) begin
        if (off_q == 9'(i)) begin
          if (we_q) wr_strobe_o[i] = 1'b1;
          else      drpdo_o        = regs[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_regs
    assign regs_o[g*16 +: 16] = regs[g];
  end

endmodule

// File: doc/drp_reg_responder.md
DRP_REG_RESPONDER -- requirements
Module: drp_reg_responder

Interface
REQ-001 Parameter NREGS, default 16, number of 16-bit registers; legal range 1..64.
REQ-002 Parameter BASE_ADDR, default 9'h000, DRP address of register 0.
REQ-003 Parameter LATENCY, default 4, cycles from accepted drpen to drprdy; legal range 1..15.
REQ-004 drp_clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 drpen_i  input  1  single-cycle transaction request.
REQ-007 drpwe_i  input  1  write when high, read when low; qualified by drpen_i.
REQ-008 drpaddr_i  input  9  DRP address.
REQ-009 drpdi_i  input  16  write data.
REQ-010 drprdy_o  output  1  single-cycle completion pulse.
REQ-011 drpdo_o  output  16  read data, valid only while drprdy_o is high.
REQ-012 regs_o  output  NREGS*16  register contents, register n at bits [n*16+15:n*16].
REQ-013 wr_strobe_o  output  NREGS  one-cycle pulse per register written.
REQ-014 addr_err_o  output  1  one-cycle pulse on out-of-range access completion.
REQ-015 busy_o  output  1  high while a transaction is in flight.
REQ-016 collision_cnt_o  output  8  count of drpen_i pulses dropped while busy.

Function
REQ-017 FSM states IDLE, WAIT, ACK; busy_o SHALL be high in WAIT and ACK.
REQ-018 IDLE: drpen_i high SHALL latch drpaddr_i, drpdi_i, drpwe_i; go to ACK if LATENCY=1, else to WAIT with down-counter loaded to LATENCY-2.
REQ-019 WAIT: counter decrements each cycle; at zero SHALL go to ACK next cycle.
REQ-020 ACK: drprdy_o high for exactly one cycle, then IDLE; drpen_i accepted at cycle t SHALL give drprdy_o at cycle t+LATENCY.
REQ-021 In range: BASE_ADDR <= addr < BASE_ADDR+NREGS (9-bit unsigned compare); index = addr-BASE_ADDR.
REQ-022 In-range write SHALL update the register so regs_o shows the new value in the drprdy_o cycle, with wr_strobe_o[index] high that cycle; drpdo_o SHALL be 16'h0000.
REQ-023 In-range read SHALL drive drpdo_o with the register value during the drprdy_o cycle.
REQ-024 Out-of-range access: no register change, drpdo_o 16'h0000, addr_err_o high during the drprdy_o cycle; drprdy_o still asserted.
REQ-025 drpdo_o SHALL be 16'h0000 whenever drprdy_o is low.
REQ-026 drpen_i high in WAIT or ACK SHALL be ignored (latched fields unchanged) and increment collision_cnt_o, saturating at 8'hFF.
REQ-027 Earliest next accepted request SHALL be the cycle after drprdy_o; back-to-back gives one transaction per LATENCY+1 cycles.
REQ-028 drpaddr_i, drpdi_i, drpwe_i SHALL be don't-care when drpen_i is low.

Reset
REQ-029 rst_n low at a drp_clk edge SHALL force IDLE, all registers 16'h0000, counter 0, collision_cnt_o 8'h00, and drprdy_o, addr_err_o, busy_o, wr_strobe_o low, drpdo_o 16'h0000.
REQ-030 Reset during WAIT or ACK SHALL abort the transaction: no drprdy_o pulse and no register update after reset.
REQ-031 drpen_i in the cycle rst_n returns high SHALL be accepted normally.

Verification
REQ-032 Write 16'hA5C3 to 9'h003, LATENCY=4, drpen at t -> drprdy_o at t+4, wr_strobe_o[3] pulse, regs_o[63:48]=16'hA5C3; read 9'h003 -> drpdo_o=16'hA5C3 with drprdy_o.
REQ-033 Read 9'h010 (NREGS=16) -> drprdy_o at t+4, addr_err_o pulse, drpdo_o=16'h0000; write 9'h1FF -> no regs_o change, addr_err_o pulse.
REQ-034 drpen_i at t, t+1, t+3 -> only t served, drprdy_o at t+4, collision_cnt_o=2; 300 drops -> saturates at 8'hFF.
REQ-035 LATENCY=1: requests at t, t+2, t+4 -> drprdy_o at t+1, t+3, t+5, none dropped.
REQ-036 Write 16'h1234 to 9'h000, rst_n low at t+2 for one cycle -> no drprdy_o, regs_o all zero, busy_o low, collision_cnt_o 0.
REQ-037 BASE_ADDR=9'h040: write 9'h041 -> register 1 updated; 9'h03F -> addr_err_o pulse.
